// File: rtl/pool_stream_unit.sv
// Streaming max / floor-average pooling over WINDOW signed samples.
// Valid/ready on both sides; one result per window, counted on acceptance.
module pool_stream_unit #(
   parameter int DATA_W = 22,
   parameter int WINDOW = 16,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mode,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     window_done,
   output logic [CNT_W-1:0]         window_count,
   output logic                     busy
);

   localparam int LOG_W = $clog2(WINDOW);
   localparam int ACC_W = DATA_W + LOG_W;

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t state_q, state_d;

   logic [LOG_W-1:0]         idx_q, idx_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [ACC_W-1:0]  samp_x, acc_upd, avg_sh;
   logic                     mode_q, mode_d, cur_mode;
   logic signed [DATA_W-1:0] res_d;
   logic [CNT_W-1:0]         cnt_d;
   logic                     done_d;
   logic                     in_fire, out_fire, last;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;
   assign last     = (idx_q == LOG_W'(WINDOW - 1));

   // The first sample of a window seeds acc and picks the mode.
   always_comb begin
      samp_x   = {{LOG_W{in_data[DATA_W-1]}}, in_data};
      cur_mode = (idx_q == '0) ? mode : mode_q;
      if (idx_q == '0)
         acc_upd = samp_x;
      else if (cur_mode)
         acc_upd = acc_q + samp_x;
      else
         acc_upd = (samp_x > acc_q) ? samp_x : acc_q;
      avg_sh = acc_upd >>> LOG_W;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      mode_d  = mode_q;
      res_d   = out_data;
      cnt_d   = window_count;
      done_d  = 1'b0;
      unique case (state_q)
         ACCUM: begin
            if (in_fire) begin
               acc_d  = acc_upd;
               mode_d = cur_mode;
               if (last) begin
                  idx_d   = '0;
                  state_d = HOLD;
                  res_d   = cur_mode ? avg_sh[DATA_W-1:0]
                                     : acc_upd[DATA_W-1:0];
               end else begin
                  idx_d = idx_q + LOG_W'(1);
               end
            end
         end
         HOLD: begin
            if (out_fire) begin
               state_d = ACCUM;
               done_d  = 1'b1;
               cnt_d   = window_count + CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ACCUM;
         idx_q        <= '0;
         acc_q        <= '0;
         mode_q       <= 1'b0;
         out_data     <= '0;
         window_count <= '0;
         window_done  <= 1'b0;
         in_ready     <= 1'b1;
         out_valid    <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         acc_q        <= acc_d;
         mode_q       <= mode_d;
         out_data     <= res_d;
         window_count <= cnt_d;
         window_done  <= done_d;
         in_ready     <= (state_d == ACCUM);
         out_valid    <= (state_d == HOLD);
         busy         <= (idx_d != '0) | (state_d == HOLD);
      end
   end

endmodule

// File: tb/tb_pool_stream_unit.sv
// Randomized bench for pool_stream_unit against a window-level model.
// A second instance with a 2-bit counter shadows the main one.
module tb_pool_stream_unit;

   localparam int DW = 22;
   localparam int W  = 16;
   localparam int CW = 16;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 mode = 1'b0;
   logic signed [DW-1:0] in_data = '0;
   logic                 in_valid = 1'b0;
   logic                 out_ready = 1'b1;
   logic                 in_ready, out_valid, window_done, busy;
   logic signed [DW-1:0] out_data;
   logic [CW-1:0]        window_count;

   logic                 in_ready2, out_valid2, window_done2, busy2;
   logic signed [DW-1:0] out_data2;
   logic [1:0]           window_count2;

   int n_vec = 0;
   int n_bad = 0;
   int cnt_exp = 0;
   int smp[W];

   always #5 clk = ~clk;

   pool_stream_unit #(.DATA_W(DW), .WINDOW(W), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .mode(mode),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .window_done(window_done), .window_count(window_count),
      .busy(busy)
   );

   pool_stream_unit #(.DATA_W(DW), .WINDOW(W), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .mode(mode),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
      .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
      .window_done(window_done2), .window_count(window_count2),
      .busy(busy2)
   );

   task automatic chk(input string tag, input longint obs,
                      input longint exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int rnd();
      logic signed [DW-1:0] r;
      r = DW'($urandom);
      return int'(r);
   endfunction

   // Pooled value of smp[] computed directly from the definition.
   function automatic longint model(input bit m);
      longint a, s;
      a = smp[0];
      s = 0;
      if (!m) begin
         for (int i = 1; i < W; i++)
            if (smp[i] > a) a = smp[i];
      end else begin
         for (int i = 0; i < W; i++) s += smp[i];
         a = s / W;
         if ((s % W != 0) && (s < 0)) a = a - 1;
      end
      return a;
   endfunction

   task automatic feed(input int cnt, input bit m_start,
                       input int flip_at, input bit gaps,
                       output bit m0, output bit ok);
      int n, cyc;
      n = 0;
      cyc = 0;
      ok = 1'b1;
      m0 = m_start;
      while (n < cnt) begin
         @(negedge clk);
         cyc++;
         if (cyc > 100 * W) begin
            chk("feed_timeout", 0, 1);
            in_valid = 1'b0;
            ok = 1'b0;
            return;
         end
         in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = DW'(smp[n]);
         mode     = (n < flip_at) ? m_start : ~m_start;
         if (in_valid && in_ready) begin
            if (n == 0) m0 = mode;
            if (n == W - 1) chk("early_valid", out_valid, 0);
            n++;
         end
      end
   endtask

   task automatic run_window(input bit m_start, input int flip_at,
                             input bit gaps, input int bp,
                             input string tag);
      bit m0, ok;
      longint e;
      out_ready = (bp == 0);
      feed(W, m_start, flip_at, gaps, m0, ok);
      if (!ok) return;
      e = model(m0);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_data"}, out_data, e);
      chk({tag, "_inrdy"}, in_ready, 0);
      chk({tag, "_busy"}, busy, 1);
      repeat (bp) begin
         @(negedge clk);
         chk({tag, "_hold_v"}, out_valid, 1);
         chk({tag, "_hold_d"}, out_data, e);
         chk({tag, "_hold_cnt"}, window_count, cnt_exp);
         chk({tag, "_hold_done"}, window_done, 0);
         chk({tag, "_hold_rdy"}, in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      cnt_exp++;
      chk({tag, "_done"}, window_done, 1);
      chk({tag, "_cnt"}, window_count, cnt_exp % (1 << CW));
      chk({tag, "_cnt2"}, window_count2, cnt_exp % 4);
      chk({tag, "_ovalid0"}, out_valid, 0);
      chk({tag, "_inrdy1"}, in_ready, 1);
      chk({tag, "_idle"}, busy, 0);
      @(negedge clk);
      chk({tag, "_done0"}, window_done, 0);
   endtask

   initial begin
      bit m0, ok;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_inrdy", in_ready, 1);
      chk("rst_ovalid", out_valid, 0);
      chk("rst_odata", out_data, 0);
      chk("rst_done", window_done, 0);
      chk("rst_cnt", window_count, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;

      for (int i = 0; i < W; i++) smp[i] = i;
      smp[7]  = -5;
      smp[12] = 1000;
      run_window(1'b0, W, 1'b0, 0, "max_seq");

      for (int i = 0; i < W; i++) smp[i] = -2097152;
      run_window(1'b0, W, 1'b0, 0, "max_neg");
      for (int i = 0; i < W; i++) smp[i] = -1;
      run_window(1'b0, W, 1'b0, 0, "max_m1");

      for (int i = 0; i < W; i++) smp[i] = 0;
      smp[0] = -3;
      run_window(1'b1, W, 1'b0, 0, "avg_floor");
      for (int i = 0; i < W; i++) smp[i] = 2097151;
      run_window(1'b1, W, 1'b0, 0, "avg_big");

      for (int i = 0; i < W; i++) smp[i] = rnd();
      run_window(1'b0, W, 1'b0, 10, "bp");

      for (int i = 0; i < W; i++) smp[i] = rnd();
      run_window(1'b0, 5, 1'b1, 0, "gap_flip");
      for (int i = 0; i < W; i++) smp[i] = rnd();
      run_window(1'b1, W, 1'b1, 2, "gap_avg");

      out_ready = 1'b1;
      for (int i = 0; i < W; i++) smp[i] = rnd();
      feed(9, 1'b1, W, 1'b0, m0, ok);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cnt_exp = 0;
      chk("midrst_busy", busy, 0);
      chk("midrst_cnt", window_count, 0);
      chk("midrst_ovalid", out_valid, 0);
      chk("midrst_inrdy", in_ready, 1);

      for (int i = 0; i < W; i++) smp[i] = 4;
      run_window(1'b1, W, 1'b0, 0, "rst_avg4");

      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < W; i++) smp[i] = rnd();
         run_window(1'($urandom_range(0, 1)), W,
                    1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), "rand");
      end
      chk("cnt_five", window_count, 5);
      chk("cnt2_wrap", window_count2, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pool_stream_unit.md
Name: pool_stream_unit

Overview:
- Streaming pooling engine that supersedes the 16-input, one-shot max-pooling block.
- Accepts signed samples serially over a valid/ready handshake and reduces each group of WINDOW samples to one result, either maximum or floor-average.
- Emits each result over a second valid/ready handshake and counts completed windows.
- Sits between the convolution output stream and the next layer's input buffer.

Parameters:
- DATA_W, 22, sample and result width; two's-complement signed.
- WINDOW, 16, samples per pooling window; power of two, range 2..256.
- CNT_W, 16, width of the completed-window counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = max pooling, 1 = average pooling; sampled on a window's first accepted sample.
- in_data  input  DATA_W  signed sample.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a sample.
- out_data  output  DATA_W  signed pooled result.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- window_done  output  1  one-cycle pulse on the cycle a result is accepted downstream.
- window_count  output  CNT_W  number of results accepted since reset; wraps modulo 2^CNT_W.
- busy  output  1  high while a window is partially accumulated or a result is pending.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values, all outputs registered:
  - in_ready = 1, out_valid = 0, out_data = 0, window_done = 0, window_count = 0, busy = 0.
  - Internal sample counter and accumulator are cleared.
- Reset wins over every other event in the same cycle. Reset mid-window discards the partial window and any pending result.
- Transfers:
  - Input transfer: in_valid & in_ready on a rising edge.
  - Output transfer: out_valid & out_ready on a rising edge.
- State machine ACCUM / HOLD:
  - ACCUM: in_ready = 1.
    - First transfer of a window (idx == 0) loads acc with the sample and latches mode into mode_q.
    - Later transfers update acc: max mode uses signed compare, strictly greater replaces; avg mode adds the sign-extended sample.
    - idx increments per transfer.
    - On the transfer with idx == WINDOW-1, the next cycle is HOLD with out_valid = 1 and out_data = final result; idx returns to 0.
  - HOLD: in_ready = 0, out_valid = 1, and out_data is stable until the output transfer.
    - On the output transfer: window_done pulses for that cycle, window_count increments, and the next state is ACCUM with in_ready = 1.
- Latency and throughput:
  - out_valid rises the cycle after the last sample transfer.
  - Throughput is WINDOW samples per WINDOW+1 cycles when out_ready is held high.
- Arithmetic:
  - Max mode: acc is DATA_W bits; the initial value is the first sample, never a constant sentinel.
  - Avg mode:
    - acc is DATA_W + log2(WINDOW) bits, signed, and cannot overflow.
    - Result = acc arithmetic-shifted right by log2(WINDOW), i.e. floor toward minus infinity, truncated to DATA_W bits (always in range).
- mode changes mid-window are ignored until the next window's first sample.
- in_valid may drop between samples; idx holds and acc holds.
- busy = (idx != 0) | out_valid.
- in_data is ignored whenever in_ready = 0.
- window_count wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Reset, mode=0, 16 samples 0..15 with sample 7 = -5 and sample 12 = 1000, out_ready=1 → out_valid is high exactly 1 cycle after the 16th transfer, out_data=1000, window_done pulses once, window_count=1.
- Max mode, all 16 samples = -2097152 (most-negative 22-bit) → out_data=-2097152. Follow with a window of all -1 → out_data=-1, with no carry-over of the previous maximum.
- Avg mode, samples {-3, then fifteen 0} → acc=-3, out_data=-1 (floor). Samples all 2097151 → out_data=2097151, no overflow.
- Backpressure: out_ready=0 for 10 cycles after out_valid rises → in_ready=0, out_data stable, window_count unchanged. Raising out_ready gives one window_done pulse. A next-window sample offered during HOLD is not consumed.
- Gapped input: in_valid toggled randomly, mode flipped to 1 at sample 5 of a max window → the result is the max of the 16 transferred samples, and the next window uses avg.
- rst asserted after 9 samples, then 16 fresh samples of value 4 in avg mode → out_data=4, window_count=1. Separately, with CNT_W=2, 5 windows → window_count=1.
